boot_loader_ctrl: RTL

- Hardware boot sequencer that copies a program image from the HD port into main memory word by word, then releases the CPU.
- Replaces the software copy loop in the boot ROM; sits between HD model, data memory write port and CPU hold input.
- Copy stops on the first all-zero word or when MAX_WORDS words have been written.
- Keeps the CPU held until the copy is complete.

---
 rtl/boot_loader_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: copies a zero-terminated image from the HD port into memory, then releases the CPU.
// Defining BOOT_CLEAR_EN adds a post-load phase that zeroes memory words 0..CLEAR_WORDS-1.

module boot_loader_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int SRC_BASE    = 0,
    parameter int DST_BASE    = 256,
    parameter int MAX_WORDS   = 256,
    parameter int CLEAR_WORDS = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              hd_rd,
    output logic [ADDR_W-1:0] hd_addr,
    input  logic [DATA_W-1:0] hd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] SRC_ADDR = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(DST_BASE);

    // Counters are ADDR_W+1 wide so a full 2^ADDR_W-word copy or clear is representable.
    if (MAX_WORDS < 1 || MAX_WORDS > (1 << ADDR_W) ||
        CLEAR_WORDS < 1 || CLEAR_WORDS > (1 << ADDR_W)) begin : g_param_check
        $error("boot_loader_ctrl: MAX_WORDS/CLEAR_WORDS out of range");
    end

`ifdef BOOT_CLEAR_EN
    typedef enum logic [2:0] {IDLE, READ, CHECK, CLEAR, DONE} state_t;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WORDS - 1);
    logic [CNT_W-1:0] clr_cnt, clr_cnt_n;
`else
    typedef enum logic [2:0] {IDLE, READ, CHECK, DONE} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] words_n;
    logic             end_load;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            words_loaded <= '0;
`ifdef BOOT_CLEAR_EN
            clr_cnt      <= '0;
`endif
        end else begin
            state        <= state_n;
            count        <= count_n;
            words_loaded <= words_n;
`ifdef BOOT_CLEAR_EN
            clr_cnt      <= clr_cnt_n;
`endif
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        count_n   = count;
        words_n   = words_loaded;
        end_load  = 1'b0;
        hd_rd     = 1'b0;
        hd_addr   = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef BOOT_CLEAR_EN
        clr_cnt_n = clr_cnt;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = READ;
                    count_n = '0;
                    words_n = '0;
                end
            end
            READ: begin
                hd_rd   = 1'b1;
                hd_addr = SRC_ADDR + count[ADDR_W-1:0];
                state_n = CHECK;
            end
            CHECK: begin
                // The zero terminator ends the load without being written.
                if (hd_data == '0) begin
                    end_load = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_addr  = DST_ADDR + count[ADDR_W-1:0];
                    mem_wdata = hd_data;
                    count_n   = count + 1'b1;
                    if (count_n == MAX_CNT) end_load = 1'b1;
                    else                    state_n  = READ;
                end
                if (end_load) begin
                    words_n = count_n;
`ifdef BOOT_CLEAR_EN
                    state_n   = CLEAR;
                    clr_cnt_n = '0;
`else
                    state_n   = DONE;
`endif
                end
            end
`ifdef BOOT_CLEAR_EN
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt[ADDR_W-1:0];
                clr_cnt_n = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) state_n = DONE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

`ifdef BOOT_CLEAR_EN
    assign busy = (state == READ) || (state == CHECK) || (state == CLEAR);
`else
    assign busy = (state == READ) || (state == CHECK);
`endif
    assign done     = (state == DONE);
    assign cpu_hold = (state != DONE);

endmodule
